// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 16-bit memory between instruction
//   fetch and the load/store path. Ldst has priority; fetch is forced after
//   MAX_LDST_STREAK consecutive ldst grants while a fetch is waiting.
// Latency: grant and memory strobes are combinational from the requests; read
//   data returns READ_LATENCY cycles after accept and is routed the same cycle.
// Backpressure: the granted requester sees i_mem_waitrequest, the other sees 1;
//   requesters hold their request stable while waitrequest is high.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_if_*  / o_if_*        fetch read port (addr, rd, waitrequest, rddata, rddatavalid)
//   i_ldst_* / o_ldst_*     load/store port (addr, rd, wr, wrdata, waitrequest, rddata, rddatavalid)
//   i_flush                 branch taken: block fetch, drop in-flight fetch reads
//   o_mem_* / i_mem_*       memory side (addr, rd, wr, wrdata, rddata, waitrequest)
module mem_port_arbiter #(
  parameter int READ_LATENCY    = 1,
  parameter int MAX_LDST_STREAK = 3
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic [15:0] i_if_addr,
  input  logic        i_if_rd,
  output logic        o_if_waitrequest,
  output logic [15:0] o_if_rddata,
  output logic        o_if_rddatavalid,
  // load/store port
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic        o_ldst_waitrequest,
  output logic [15:0] o_ldst_rddata,
  output logic        o_ldst_rddatavalid,
  // branch flush
  input  logic        i_flush,
  // memory port
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic [15:0] i_mem_rddata,
  input  logic        i_mem_waitrequest
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LDST_STREAK);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LDST = 2'd2
  } gnt_e;

  // Consecutive ldst accepts while a fetch was waiting.
  logic [3:0]              r_streak;
  // Read tracker: bit 0 is the head, bit READ_LATENCY-1 the tail.
  // r_own = 1 marks a ldst read, 0 a fetch read.
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_own;
  // Last delivered words, held between responses.
  logic [15:0]             r_if_rddata;
  logic [15:0]             r_ldst_rddata;

  logic       w_ldst_req;
  logic       w_if_req;
  logic       w_ldst_is_wr;
  logic       w_ldst_is_rd;
  gnt_e       w_gnt;
  logic       w_accept;
  logic       w_accept_rd;
  logic [3:0] w_streak_nxt;
  logic       w_tail_vld;
  logic       w_tail_if;
  logic       w_tail_ldst;

  // ---------------------------------------------------------------------------
  // Request decode and grant. Reset blocks both requesters so the memory side
  // is quiet and both waitrequests read 1 while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ldst_req   = (i_ldst_rd | i_ldst_wr) & ~reset;
    w_if_req     = i_if_rd & ~i_flush & ~reset;
    // A simultaneous rd+wr is a store; the read half is ignored.
    w_ldst_is_wr = i_ldst_wr;
    w_ldst_is_rd = i_ldst_rd & ~i_ldst_wr;

    w_gnt = GNT_NONE;
    if (w_ldst_req && w_if_req) begin
      w_gnt = (r_streak == STREAK_MAX) ? GNT_IF : GNT_LDST;
    end else if (w_ldst_req) begin
      w_gnt = GNT_LDST;
    end else if (w_if_req) begin
      w_gnt = GNT_IF;
    end
  end

  assign w_accept    = (w_gnt != GNT_NONE) & ~i_mem_waitrequest;
  assign w_accept_rd = w_accept & ((w_gnt == GNT_IF) | ((w_gnt == GNT_LDST) & w_ldst_is_rd));

  // ---------------------------------------------------------------------------
  // Memory side and per-requester waitrequest.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_addr         = 16'h0000;
    o_mem_rd           = 1'b0;
    o_mem_wr           = 1'b0;
    o_mem_wrdata       = 16'h0000;
    o_if_waitrequest   = 1'b1;
    o_ldst_waitrequest = 1'b1;
    case (w_gnt)
      GNT_IF: begin
        o_mem_addr       = i_if_addr;
        o_mem_rd         = 1'b1;
        o_if_waitrequest = i_mem_waitrequest;
      end
      GNT_LDST: begin
        o_mem_addr         = i_ldst_addr;
        o_mem_rd           = w_ldst_is_rd;
        o_mem_wr           = w_ldst_is_wr;
        o_mem_wrdata       = i_ldst_wrdata;
        o_ldst_waitrequest = i_mem_waitrequest;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch starvation guard. The streak only matters while a fetch is waiting,
  // so it restarts whenever i_if_rd drops. A stalled cycle (no accept) holds it.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_if_rd) begin
      w_streak_nxt = 4'd0;
    end else if (w_accept && (w_gnt == GNT_IF)) begin
      w_streak_nxt = 4'd0;
    end else if (w_accept && (w_gnt == GNT_LDST) && (r_streak != STREAK_MAX)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing. The tail entry lines up with i_mem_rddata this cycle.
  // A flush kills a fetch entry even when it is already at the tail.
  // ---------------------------------------------------------------------------
  assign w_tail_vld  = r_vld[READ_LATENCY-1] & ~reset;
  assign w_tail_if   = w_tail_vld & ~r_own[READ_LATENCY-1] & ~i_flush;
  assign w_tail_ldst = w_tail_vld &  r_own[READ_LATENCY-1];

  assign o_if_rddatavalid   = w_tail_if;
  assign o_ldst_rddatavalid = w_tail_ldst;
  assign o_if_rddata        = w_tail_if   ? i_mem_rddata : r_if_rddata;
  assign o_ldst_rddata      = w_tail_ldst ? i_mem_rddata : r_ldst_rddata;

  // ---------------------------------------------------------------------------
  // State.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak      <= 4'd0;
      r_vld         <= '0;
      r_own         <= '0;
      r_if_rddata   <= 16'h0000;
      r_ldst_rddata <= 16'h0000;
    end else begin
      r_streak <= w_streak_nxt;

      r_vld[0] <= w_accept_rd;
      r_own[0] <= (w_gnt == GNT_LDST);
      // Shift toward the tail; fetch entries die while flush is high.
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1] & ~(i_flush & ~r_own[k-1]);
        r_own[k] <= r_own[k-1];
      end

      if (w_tail_if) begin
        r_if_rddata <= i_mem_rddata;
      end
      if (w_tail_ldst) begin
        r_ldst_rddata <= i_mem_rddata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (READ_LATENCY 1, 2, 3) share one
//   directed stimulus stream; grant decisions are identical across them, only
//   response timing differs. Memory models return addr ^ 16'h5A5A.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] i_if_addr = '0;
  logic        i_if_rd = 1'b0;
  logic [15:0] i_ldst_addr = '0;
  logic        i_ldst_rd = 1'b0;
  logic        i_ldst_wr = 1'b0;
  logic [15:0] i_ldst_wrdata = '0;
  logic        i_flush = 1'b0;
  logic        mem_wait = 1'b0;

  logic [2:0]  if_wait, if_vld, ld_wait, ld_vld, m_rd, m_wr;
  logic [15:0] if_dat [3];
  logic [15:0] ld_dat [3];
  logic [15:0] m_addr [3];
  logic [15:0] m_wd   [3];
  logic [15:0] m_rdd  [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        own;   // 1 = ldst, 0 = fetch
    logic [15:0] dat;
    logic [31:0] due;
  } exp_t;
  exp_t q [3][$];

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    logic [15:0] pipe [0:g];
    mem_port_arbiter #(.READ_LATENCY(g + 1), .MAX_LDST_STREAK(3)) u_dut (
      .clk                (clk),
      .reset              (reset),
      .i_if_addr          (i_if_addr),
      .i_if_rd            (i_if_rd),
      .o_if_waitrequest   (if_wait[g]),
      .o_if_rddata        (if_dat[g]),
      .o_if_rddatavalid   (if_vld[g]),
      .i_ldst_addr        (i_ldst_addr),
      .i_ldst_rd          (i_ldst_rd),
      .i_ldst_wr          (i_ldst_wr),
      .i_ldst_wrdata      (i_ldst_wrdata),
      .o_ldst_waitrequest (ld_wait[g]),
      .o_ldst_rddata      (ld_dat[g]),
      .o_ldst_rddatavalid (ld_vld[g]),
      .i_flush            (i_flush),
      .o_mem_addr         (m_addr[g]),
      .o_mem_rd           (m_rd[g]),
      .o_mem_wr           (m_wr[g]),
      .o_mem_wrdata       (m_wd[g]),
      .i_mem_rddata       (m_rdd[g]),
      .i_mem_waitrequest  (mem_wait)
    );
    // Fixed-latency memory: word valid g+1 cycles after an accepted read.
    always @(posedge clk) begin
      pipe[0] <= (m_rd[g] && !mem_wait) ? (m_addr[g] ^ 16'h5A5A) : 16'h0000;
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end
    assign m_rdd[g] = pipe[g];
  end

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus. eg is the hand-computed grant: 0 none, 1 fetch, 2 ldst.
  task automatic step(input logic ifr, input logic [15:0] ifa,
                      input logic ldr, input logic ldw, input logic [15:0] lda,
                      input logic [15:0] wd, input logic fl, input logic mw,
                      input int eg);
    logic        e_rd, e_wr, e_ifw, e_ldw;
    logic [15:0] e_addr, e_wd;
    @(negedge clk);
    reset = 1'b0;
    i_if_rd = ifr; i_if_addr = ifa;
    i_ldst_rd = ldr; i_ldst_wr = ldw; i_ldst_addr = lda; i_ldst_wrdata = wd;
    i_flush = fl; mem_wait = mw;
    if (fl) begin
      for (int i = 0; i < 3; i++)
        for (int j = q[i].size() - 1; j >= 0; j--)
          if (!q[i][j].own && q[i][j].due >= 32'(cyc)) q[i].delete(j);
    end
    case (eg)
      1:       begin e_rd = 1'b1; e_wr = 1'b0; e_addr = ifa; e_wd = 16'h0; e_ifw = mw;   e_ldw = 1'b1; end
      2:       begin e_rd = ldr & ~ldw; e_wr = ldw; e_addr = lda; e_wd = wd; e_ifw = 1'b1; e_ldw = mw; end
      default: begin e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wd = 16'h0; e_ifw = 1'b1; e_ldw = 1'b1; end
    endcase
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mem_rd[%0d] c%0d", i, cyc),   {16'h0, m_rd[i]},    {16'h0, e_rd});
      chk($sformatf("mem_wr[%0d] c%0d", i, cyc),   {16'h0, m_wr[i]},    {16'h0, e_wr});
      chk($sformatf("mem_addr[%0d] c%0d", i, cyc), {1'b0, m_addr[i]},   {1'b0, e_addr});
      chk($sformatf("mem_wrdata[%0d] c%0d", i, cyc), {1'b0, m_wd[i]},   {1'b0, e_wd});
      chk($sformatf("if_wait[%0d] c%0d", i, cyc),  {16'h0, if_wait[i]}, {16'h0, e_ifw});
      chk($sformatf("ldst_wait[%0d] c%0d", i, cyc), {16'h0, ld_wait[i]}, {16'h0, e_ldw});
    end
    if (eg != 0 && !mw) begin
      for (int i = 0; i < 3; i++) begin
        if (eg == 1)
          q[i].push_back('{own: 1'b0, dat: ifa ^ 16'h5A5A, due: 32'(cyc + i + 1)});
        else if (ldr && !ldw)
          q[i].push_back('{own: 1'b1, dat: lda ^ 16'h5A5A, due: 32'(cyc + i + 1)});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    i_if_rd = 1'b0; i_ldst_rd = 1'b0; i_ldst_wr = 1'b0; i_flush = 1'b0; mem_wait = 1'b0;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst mem_rd[%0d]", i),    {16'h0, m_rd[i]},    17'h0);
      chk($sformatf("rst mem_wr[%0d]", i),    {16'h0, m_wr[i]},    17'h0);
      chk($sformatf("rst if_wait[%0d]", i),   {16'h0, if_wait[i]}, 17'h1);
      chk($sformatf("rst ldst_wait[%0d]", i), {16'h0, ld_wait[i]}, 17'h1);
      chk($sformatf("rst if_vld[%0d]", i),    {16'h0, if_vld[i]},  17'h0);
      chk($sformatf("rst ldst_vld[%0d]", i),  {16'h0, ld_vld[i]},  17'h0);
    end
    repeat (n) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst if_rddata[%0d]", i),   {1'b0, if_dat[i]}, 17'h0);
      chk($sformatf("rst ldst_rddata[%0d]", i), {1'b0, ld_dat[i]}, 17'h0);
      chk($sformatf("rst mem_addr[%0d]", i),    {1'b0, m_addr[i]}, 17'h0);
    end
  endtask

  // Response monitor: every presented pulse must match the queue head, and a
  // head whose due cycle arrives without a pulse is a missing response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (if_vld[i] || ld_vld[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL resp[%0d] c%0d: got unexpected pulse if=%0b ldst=%0b, required none", i, cyc, if_vld[i], ld_vld[i]);
          end else begin
            exp_t e;
            logic [15:0] d;
            e = q[i].pop_front();
            d = e.own ? ld_dat[i] : if_dat[i];
            if (e.due != 32'(cyc) || (if_vld[i] && ld_vld[i]) || ld_vld[i] != e.own || d != e.dat) begin
              errors++;
              $display("FAIL resp[%0d] c%0d: got if=%0b ldst=%0b data=%h, required owner_ldst=%0b data=%h at c%0d",
                       i, cyc, if_vld[i], ld_vld[i], d, e.own, e.dat, e.due);
            end
          end
        end else if (q[i].size() > 0 && q[i][0].due <= 32'(cyc)) begin
          exp_t e;
          e = q[i].pop_front();
          checks++;
          errors++;
          $display("FAIL resp[%0d] c%0d: got no pulse, required owner_ldst=%0b data=%h", i, cyc, e.own, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);

    // Fetch only, back-to-back.
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1);
    idle(4);

    // Both request every cycle: ldst x3 then forced fetch, twice.
    step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0102, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0104, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0106, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 16'h0012, 1'b1, 1'b0, 16'h0106, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0012, 1'b1, 1'b0, 16'h0108, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0012, 1'b1, 1'b0, 16'h010A, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0012, 1'b1, 1'b0, 16'h010C, 16'h0, 1'b0, 1'b0, 1);
    idle(4);

    // Store beats fetch, fetch next; then rd+wr together acts as a store.
    step(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'hCAFE, 1'b0, 1'b0, 2);
    idle(4);

    // Flush: fetch, fetch, load, then flush with fetch still requesting.
    step(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 16'h0032, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0034, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 0);
    idle(5);

    // Stall: streak reaches 2, two stalled ldst cycles hold it, accept takes
    // it to 3, so the next contended cycle must go to fetch.
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0072, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0074, 16'h0, 1'b0, 1'b1, 2);
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0074, 16'h0, 1'b0, 1'b1, 2);
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0074, 16'h0, 1'b0, 1'b0, 2);
    step(1'b1, 16'h0060, 1'b1, 1'b0, 16'h0076, 16'h0, 1'b0, 1'b0, 1);
    idle(5);

    // Reset with reads in flight; nothing may come back afterwards.
    step(1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1);
    step(1'b1, 16'h0082, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 1);
    do_reset(2);
    idle(6);

    for (int i = 0; i < 3; i++)
      chk($sformatf("pending responses[%0d]", i), 17'(q[i].size()), 17'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
